// File: rtl/m_ifetch_queue.sv
// m_ifetch_queue: fetch PC, instruction memory address and {pc, insn} FIFO.
// Optional macro IFETCH_PERFCNT_EN adds fetch and flush event counters.
module m_ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 12,
    parameter int          QDEPTH   = 2
) (
    input  logic              w_clk,
    input  logic              w_rst,
    output logic [ADDR_W-1:0] w_imem_addr,
    input  logic [31:0]       w_imem_data,
    input  logic              w_redirect,
    input  logic [31:0]       w_redirect_pc,
    input  logic              w_ir_ready,
    output logic              w_ir_valid,
    output logic [31:0]       w_ir,
    output logic [31:0]       w_ir_pc,
    output logic [31:0]       w_ir_npc
`ifdef IFETCH_PERFCNT_EN
    ,
    output logic [31:0]       w_fetch_cnt,
    output logic [31:0]       w_flush_cnt
`endif
);

    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fpc_q, fpc_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q [QDEPTH];
    logic [31:0]   ir_q [QDEPTH];

    logic pop;
    logic push;

    // Handshake terms; a redirect suppresses the fetch of the wrong path.
    always_comb begin
        pop  = w_ir_valid & w_ir_ready;
        push = ~w_redirect & ((cnt_q < CW'(QDEPTH)) | pop);
    end

    // Next-state for PC, pointers and occupancy; redirect dominates.
    always_comb begin
        fpc_d  = fpc_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (w_redirect) begin
            fpc_d  = {w_redirect_pc[31:2], 2'b00};
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                fpc_d  = fpc_q + 32'd4;
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            fpc_q  <= PC_RST;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            fpc_q  <= fpc_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q[i] <= '0;
                ir_q[i] <= '0;
            end
        end else if (push) begin
            pc_q[wptr_q] <= fpc_q;
            ir_q[wptr_q] <= w_imem_data;
        end
    end

    // Head outputs come straight from storage, never from memory data.
    always_comb begin
        w_imem_addr = fpc_q[ADDR_W+1:2];
        w_ir_valid  = (cnt_q != '0);
        w_ir        = ir_q[rptr_q];
        w_ir_pc     = pc_q[rptr_q];
        w_ir_npc    = pc_q[rptr_q] + 32'd4;
    end

`ifdef IFETCH_PERFCNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A popped head is not counted as discarded by a redirect.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, push};
        flush_cnt_d = flush_cnt_q;
        if (w_redirect) begin
            flush_cnt_d = flush_cnt_q + 32'(cnt_q) - {31'd0, pop};
        end
    end

    // Event counters, wrapping at 2^32.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign w_fetch_cnt = fetch_cnt_q;
    assign w_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Directed bench for m_ifetch_queue: vector table plus reset sequences.
// u0: RESET_PC 0, QDEPTH 2. u1: RESET_PC FFFFFFF8, QDEPTH 4, always ready.
module tb_m_ifetch_queue;

    logic        clk;
    logic        rst;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic        rd0;
    logic [31:0] rpc0;
    logic        rdy0;
    logic        v0, v1;
    logic [31:0] ir0, ir1, pc0, pc1, npc0, npc1;
`ifdef IFETCH_PERFCNT_EN
    logic [31:0] fc0, fl0, fc1, fl1;
`endif

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] memf(input logic [11:0] a);
        case (a)
            12'd0:   memf = 32'd11;
            12'd1:   memf = 32'd22;
            12'd2:   memf = 32'd33;
            12'd3:   memf = 32'd44;
            default: memf = 32'h100 + {20'h0, a};
        endcase
    endfunction

    assign d0 = memf(a0);
    assign d1 = memf(a1);

    m_ifetch_queue #(.RESET_PC(32'h0), .ADDR_W(12), .QDEPTH(2)) u0 (
        .w_clk(clk), .w_rst(rst),
        .w_imem_addr(a0), .w_imem_data(d0),
        .w_redirect(rd0), .w_redirect_pc(rpc0),
        .w_ir_ready(rdy0), .w_ir_valid(v0),
        .w_ir(ir0), .w_ir_pc(pc0), .w_ir_npc(npc0)
`ifdef IFETCH_PERFCNT_EN
        , .w_fetch_cnt(fc0), .w_flush_cnt(fl0)
`endif
    );

    m_ifetch_queue #(.RESET_PC(32'hFFFF_FFF8), .ADDR_W(12), .QDEPTH(4)) u1 (
        .w_clk(clk), .w_rst(rst),
        .w_imem_addr(a1), .w_imem_data(d1),
        .w_redirect(1'b0), .w_redirect_pc(32'h0),
        .w_ir_ready(1'b1), .w_ir_valid(v1),
        .w_ir(ir1), .w_ir_pc(pc1), .w_ir_npc(npc1)
`ifdef IFETCH_PERFCNT_EN
        , .w_fetch_cnt(fc1), .w_flush_cnt(fl1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eir;
        logic [11:0] eaddr;
    } vec_t;

    vec_t tv [20];
    logic [31:0] u1pc [4];

    function automatic vec_t mk(input logic rdy, input logic rd,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc,
                                input logic [31:0] eir,
                                input logic [11:0] eaddr);
        vec_t t;
        t.rdy = rdy; t.rd = rd; t.rpc = rpc;
        t.ev = ev; t.epc = epc; t.eir = eir; t.eaddr = eaddr;
        return t;
    endfunction

    initial begin
        // row: inputs applied after checking the current state
        tv[0]  = mk(1, 0, 0,     0, 0,  0,      0);
        tv[1]  = mk(1, 0, 0,     1, 0,  11,     1);
        tv[2]  = mk(1, 0, 0,     1, 4,  22,     2);
        tv[3]  = mk(1, 0, 0,     1, 8,  33,     3);
        tv[4]  = mk(0, 1, 0,     1, 12, 44,     4);
        tv[5]  = mk(0, 0, 0,     0, 0,  0,      0);
        tv[6]  = mk(0, 0, 0,     1, 0,  11,     1);
        tv[7]  = mk(0, 0, 0,     1, 0,  11,     2);
        tv[8]  = mk(0, 0, 0,     1, 0,  11,     2);
        tv[9]  = mk(0, 0, 0,     1, 0,  11,     2);
        tv[10] = mk(1, 0, 0,     1, 0,  11,     2);
        tv[11] = mk(1, 0, 0,     1, 4,  22,     3);
        tv[12] = mk(0, 0, 0,     1, 8,  33,     4);
        tv[13] = mk(0, 1, 32'h13, 1, 8, 33,     4);
        tv[14] = mk(1, 0, 0,     0, 0,  0,      4);
        tv[15] = mk(1, 1, 40,    1, 16, 32'h104, 5);
        tv[16] = mk(1, 1, 80,    0, 0,  0,      10);
        tv[17] = mk(1, 0, 0,     0, 0,  0,      20);
        tv[18] = mk(1, 0, 0,     1, 80, 32'h114, 21);
        tv[19] = mk(1, 0, 0,     1, 84, 32'h115, 22);
        u1pc[0] = 32'hFFFF_FFF8;
        u1pc[1] = 32'hFFFF_FFFC;
        u1pc[2] = 32'h0;
        u1pc[3] = 32'h4;

        rst = 1'b1; rd0 = 1'b0; rpc0 = '0; rdy0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst valid", {31'd0, v0}, 0);
        chk("rst ir", ir0, 0);
        chk("rst pc", pc0, 0);
        chk("rst npc", npc0, 4);
        chk("rst addr", {20'd0, a0}, 0);
        chk("rst u1 addr", {20'd0, a1}, 32'hFFE);
        chk("rst u1 valid", {31'd0, v1}, 0);
`ifdef IFETCH_PERFCNT_EN
        chk("rst fetch_cnt", fc0, 0);
        chk("rst flush_cnt", fl0, 0);
`endif
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            chk($sformatf("r%0d valid", k), {31'd0, v0}, {31'd0, tv[k].ev});
            chk($sformatf("r%0d addr", k), {20'd0, a0}, {20'd0, tv[k].eaddr});
            if (tv[k].ev) begin
                chk($sformatf("r%0d pc", k), pc0, tv[k].epc);
                chk($sformatf("r%0d ir", k), ir0, tv[k].eir);
                chk($sformatf("r%0d npc", k), npc0, tv[k].epc + 32'd4);
            end
            if (k >= 1 && k <= 4) begin
                chk($sformatf("u1 r%0d valid", k), {31'd0, v1}, 1);
                chk($sformatf("u1 r%0d pc", k), pc1, u1pc[k-1]);
                chk($sformatf("u1 r%0d npc", k), npc1, u1pc[k-1] + 32'd4);
            end
            rdy0 = tv[k].rdy;
            rd0  = tv[k].rd;
            rpc0 = tv[k].rpc;
            @(negedge clk);
        end

        chk("tail pc", pc0, 88);
`ifdef IFETCH_PERFCNT_EN
        chk("fetch_cnt", fc0, 12);
        chk("flush_cnt", fl0, 3);
`endif
        rdy0 = 1'b0;
        rd0  = 1'b0;
        @(posedge clk);
        #2;
        chk("pre-rst valid", {31'd0, v0}, 1);
        rst = 1'b1;
        #1;
        chk("async rst valid", {31'd0, v0}, 0);
        chk("async rst addr", {20'd0, a0}, 0);
        chk("async rst u1 valid", {31'd0, v1}, 0);
`ifdef IFETCH_PERFCNT_EN
        chk("async rst fetch_cnt", fc0, 0);
        chk("async rst flush_cnt", fl0, 0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        rdy0 = 1'b1;
        @(negedge clk);
        chk("restart valid", {31'd0, v0}, 1);
        chk("restart pc", pc0, 0);
        chk("restart ir", ir0, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
